// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_wb_ctrl_pkg: shared widths, source indices and write-entry type
// for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO that also exposes every slot's valid bit
// and destination address so the owner can build a pending-write bitmap.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int WIDTH  = 37,
    parameter int ADDR_W = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    output logic                      full_o,
    input  logic                      pop_i,
    output logic                      empty_o,
    output logic [WIDTH-1:0]          head_o,
    output logic [DEPTH-1:0]          ent_valid_o,
    output logic [DEPTH*ADDR_W-1:0]   ent_addr_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, cnt;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = wr_q + PW'(do_push);
    assign rd_d    = rd_q + PW'(do_pop);
    assign head_o  = mem_q[rd_q[IW-1:0]];
    assign cnt     = wr_q - rd_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [IW-1:0] off;
        assign off                          = IW'(i) - rd_q[IW-1:0];
        assign ent_valid_o[i]               = {1'b0, off} < cnt;
        assign ent_addr_o[i*ADDR_W +: ADDR_W] = mem_q[i][WIDTH-1 -: ADDR_W];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[IW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin write-back of ALU and LSU results into the
// single register-file write port, with a pending-write bitmap for issue stalls.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter bit DROP_X0 = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REG_ADDR_W-1:0] alu_addr_i,
    input  logic [DATA_W-1:0]     alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0]     lsu_data_i,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [NUM_REGS-1:0]   pend_o
);
    wb_entry_t                     alu_head, lsu_head, head;
    logic                          alu_full, alu_empty, lsu_full, lsu_empty;
    logic                          alu_pop, lsu_pop, pop, grant, issue;
    logic [DEPTH-1:0]              alu_vld, lsu_vld;
    logic [DEPTH*REG_ADDR_W-1:0]   alu_addrs, lsu_addrs;
    logic                          last_q, last_d, we_q, we_d;
    logic [REG_ADDR_W-1:0]         waddr_q, waddr_d;
    logic [DATA_W-1:0]             wdata_q, wdata_d;

    function automatic logic [NUM_REGS-1:0] mark(input logic v, input logic [REG_ADDR_W-1:0] a);
        return (v && !(DROP_X0 && a == '0)) ? reg_bit(a) : '0;
    endfunction

    assign alu_ready_o = !alu_full;
    assign lsu_ready_o = !lsu_full;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .ADDR_W(REG_ADDR_W)) u_alu_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (alu_valid_i),
        .push_data_i ({alu_addr_i, alu_data_i}),
        .full_o      (alu_full),
        .pop_i       (alu_pop),
        .empty_o     (alu_empty),
        .head_o      (alu_head),
        .ent_valid_o (alu_vld),
        .ent_addr_o  (alu_addrs)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .ADDR_W(REG_ADDR_W)) u_lsu_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (lsu_valid_i),
        .push_data_i ({lsu_addr_i, lsu_data_i}),
        .full_o      (lsu_full),
        .pop_i       (lsu_pop),
        .empty_o     (lsu_empty),
        .head_o      (lsu_head),
        .ent_valid_o (lsu_vld),
        .ent_addr_o  (lsu_addrs)
    );

    // last_q holds the source granted most recently; contention goes to the other one.
    always_comb begin
        grant   = (!alu_empty && !lsu_empty) ? ~last_q : (alu_empty ? SRC_LSU : SRC_ALU);
        pop     = !alu_empty || !lsu_empty;
        alu_pop = pop && (grant == SRC_ALU);
        lsu_pop = pop && (grant == SRC_LSU);
        head    = (grant == SRC_LSU) ? lsu_head : alu_head;
        issue   = pop && !(DROP_X0 && head.addr == '0);
        last_d  = pop ? grant : last_q;
        we_d    = issue;
        waddr_d = pop ? head.addr : waddr_q;
        wdata_d = pop ? head.data : wdata_q;
    end

    always_comb begin
        pend_o = we_q ? reg_bit(waddr_q) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_o = pend_o | mark(alu_vld[i], alu_addrs[i*REG_ADDR_W +: REG_ADDR_W])
                            | mark(lsu_vld[i], lsu_addrs[i*REG_ADDR_W +: REG_ADDR_W]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q  <= SRC_LSU;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed checks of write-back ordering, latency,
// reset behaviour, pending bitmap and address-0 dropping.
module tb_regfile_wb_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        a_v = 1'b0, l_v = 1'b0, a_r, l_r, we;
    logic [4:0]  a_a = '0, l_a = '0, wa;
    logic [31:0] a_d = '0, l_d = '0, wd, pend;
    logic        d_v = 1'b0, d_lv = 1'b0, d_r, d_lr, d_we;
    logic [4:0]  d_a = '0, d_la = '0, d_wa;
    logic [31:0] d_d = '0, d_ld = '0, d_wd, d_pend;
    logic [31:0] rf [32];
    int          wq [$];
    int          total = 0, bad = 0, we_cnt = 0, d_we_cnt = 0;

    regfile_wb_ctrl #(.DEPTH(2), .DROP_X0(1'b0)) dut (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(a_v), .alu_ready_o(a_r), .alu_addr_i(a_a), .alu_data_i(a_d),
        .lsu_valid_i(l_v), .lsu_ready_o(l_r), .lsu_addr_i(l_a), .lsu_data_i(l_d),
        .we_o(we), .waddr_o(wa), .wdata_o(wd), .pend_o(pend)
    );

    regfile_wb_ctrl #(.DEPTH(2), .DROP_X0(1'b1)) dut_drop (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(d_v), .alu_ready_o(d_r), .alu_addr_i(d_a), .alu_data_i(d_d),
        .lsu_valid_i(d_lv), .lsu_ready_o(d_lr), .lsu_addr_i(d_la), .lsu_data_i(d_ld),
        .we_o(d_we), .waddr_o(d_wa), .wdata_o(d_wd), .pend_o(d_pend)
    );

    always #5 clk = ~clk;

    // Register-file model: commits on the edge that ends a WE cycle.
    always @(posedge clk) begin
        if (we === 1'b1) begin
            rf[wa] <= wd;
            wq.push_back(int'(wa));
            we_cnt++;
        end
        if (d_we === 1'b1) d_we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  ai, li, n, base;
        bit  saw_low, aacc, lacc;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        a_v = 1'b1; a_a = 5'd5; a_d = 32'hDEADBEEF;
        #1 check("sw_ready", a_r, 1);
        @(negedge clk);
        a_v = 1'b0;
        check("sw_pend_n", pend, 32'h20);
        check("sw_we_n", we, 0);
        @(negedge clk);
        check("sw_we", we, 1);
        check("sw_waddr", wa, 5);
        check("sw_wdata", wd, 32'hDEADBEEF);
        check("sw_pend_n1", pend, 32'h20);
        @(negedge clk);
        check("sw_we_off", we, 0);
        check("sw_pend_clr", pend, 0);
        check("sw_rf5", rf[5], 32'hDEADBEEF);

        @(negedge clk);
        a_v = 1'b1; a_a = 5'd7; a_d = 32'h7;
        @(negedge clk);
        a_v = 1'b0;
        check("rst_pre_pend", pend, 32'h80);
        #2 rst = 1'b1;
        #1;
        check("rst_we", we, 0);
        check("rst_waddr", wa, 0);
        check("rst_wdata", wd, 0);
        check("rst_pend", pend, 0);
        check("rst_alu_rdy", a_r, 1);
        check("rst_lsu_rdy", l_r, 1);
        @(negedge clk);
        rst = 1'b0;

        base = wq.size(); ai = 0; li = 0; n = 0; saw_low = 1'b0;
        while ((ai < 4 || li < 4) && n < 30) begin
            @(negedge clk);
            a_v = ai < 4; a_a = 5'(2*ai + 1); a_d = 32'h100 + 32'(2*ai + 1);
            l_v = li < 4; l_a = 5'(2*li + 2); l_d = 32'h100 + 32'(2*li + 2);
            #1;
            if (!a_r || !l_r) saw_low = 1'b1;
            aacc = a_v && a_r;
            lacc = l_v && l_r;
            @(posedge clk);
            ai += int'(aacc);
            li += int'(lacc);
            n++;
        end
        @(negedge clk);
        a_v = 1'b0; l_v = 1'b0;
        check("ctn_sent", ai + li, 8);
        repeat (8) @(negedge clk);
        check("ctn_count", wq.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < wq.size()) check("ctn_order", wq[base+k], k + 1);
            else check("ctn_missing", 32'hFFFF_FFFF, k + 1);
            check("ctn_data", rf[k+1], 32'h100 + 32'(k + 1));
        end
        check("ctn_ready_drop", saw_low, 1);

        @(negedge clk);
        a_v = 1'b1; a_a = 5'd20; a_d = 32'h20;
        l_v = 1'b1; l_a = 5'd10; l_d = 32'h10;
        @(negedge clk);
        a_a = 5'd21; a_d = 32'h21;
        l_a = 5'd11; l_d = 32'h11;
        @(negedge clk);
        a_v = 1'b0; l_v = 1'b0;
        check("bl_lsu_full", l_r, 0);
        check("bl_we", we, 1);
        check("bl_waddr", wa, 20);
        check("bl_pend", pend, 32'h0030_0C00);
        #2 rst = 1'b1;
        #1;
        check("bl_rst_pend", pend, 0);
        check("bl_rst_we", we, 0);
        base = we_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("bl_no_we", we_cnt - base, 0);
        check("bl_pend_after", pend, 0);

        @(negedge clk);
        a_v = 1'b1; a_a = 5'd0; a_d = 32'h55;
        @(negedge clk);
        a_v = 1'b0;
        check("x0_pend", pend, 32'h1);
        @(negedge clk);
        check("x0_we", we, 1);
        check("x0_waddr", wa, 0);
        @(negedge clk);
        check("x0_pend_clr", pend, 0);

        @(negedge clk);
        a_v = 1'b1; a_a = 5'd3; a_d = 32'hA;
        @(negedge clk);
        a_d = 32'hB;
        check("same_pend0", pend[3], 1);
        @(negedge clk);
        a_v = 1'b0;
        check("same_pend1", pend[3], 1);
        check("same_wdA", wd, 32'hA);
        @(negedge clk);
        check("same_pend2", pend[3], 1);
        check("same_we2", we, 1);
        check("same_wdB", wd, 32'hB);
        @(negedge clk);
        check("same_pend_clr", pend[3], 0);
        check("same_we_off", we, 0);
        check("same_rf3", rf[3], 32'hB);

        @(negedge clk);
        d_v = 1'b1; d_a = 5'd0; d_d = 32'h1234;
        #1 check("drop_ready", d_r, 1);
        base = d_we_cnt;
        @(negedge clk);
        d_v = 1'b0;
        check("drop_pend_n", d_pend, 0);
        repeat (3) begin
            @(negedge clk);
            check("drop_pend0", d_pend[0], 0);
            check("drop_we", d_we, 0);
        end
        check("drop_we_cnt", d_we_cnt - base, 0);
        @(negedge clk);
        d_v = 1'b1; d_a = 5'd9; d_d = 32'h99;
        @(negedge clk);
        d_v = 1'b0;
        check("drop9_pend", d_pend, 32'h200);
        @(negedge clk);
        check("drop9_we", d_we, 1);
        check("drop9_waddr", d_wa, 9);
        check("drop9_wdata", d_wd, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
